// File: rtl/rf_scoreboard.sv
// Decode-stage register file with write-back bypass and a pending-write scoreboard.
// Read ports are combinational; issue marks a destination busy, write-back retires it.
module rf_scoreboard #(
    parameter int WORD_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic                        clk,
    input  logic                        rf_reset,
    input  logic                        clr,
    input  logic                        stall,
    input  logic [NUM_RD*REG_IDX_W-1:0] i_rd_idx,
    output logic [NUM_RD*WORD_W-1:0]    o_rd_data,
    output logic [NUM_RD-1:0]           o_rd_ready,
    input  logic                        i_issue_en,
    input  logic [REG_IDX_W-1:0]        i_issue_reg,
    output logic                        o_issue_ok,
    input  logic [NUM_WR-1:0]           i_wb_en,
    input  logic [NUM_WR*REG_IDX_W-1:0] i_wb_reg,
    input  logic [NUM_WR*WORD_W-1:0]    i_wb_data,
    output logic [REG_IDX_W:0]          o_busy_cnt
);

    localparam int NUM_REGS = 2**REG_IDX_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [WORD_W-1:0]   regs   [NUM_REGS];
    logic [WORD_W-1:0]   wb_val [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] cleared;
    logic [REG_IDX_W:0]  busy_cnt;
    logic [REG_IDX_W:0]  busy_cnt_next;
    logic [REG_IDX_W:0]  dec_cnt;
    logic                issue_ok;
    logic                issue_sets;
    logic                inc;

    // Per-register write-back decode; later ports overwrite earlier ones so the
    // highest port index wins for both bypass and storage.
    always_comb begin
        // NOTE: every combinationally written signal gets a default first so no latch is inferred.
        wb_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wb_val[r] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_wb_en[w] && (i_wb_reg[w*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r))) begin
                    wb_hit[r] = 1'b1;
                    wb_val[r] = i_wb_data[w*WORD_W +: WORD_W];
                end
            end
        end
        if (HAS_ZERO) begin
            wb_hit[0] = 1'b0;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [REG_IDX_W-1:0] idx;
        logic                 zero_hit;
        assign idx      = i_rd_idx[p*REG_IDX_W +: REG_IDX_W];
        assign zero_hit = HAS_ZERO && (idx == '0);
        assign o_rd_data[p*WORD_W +: WORD_W] = zero_hit    ? '0 :
                                               wb_hit[idx] ? wb_val[idx] : regs[idx];
        assign o_rd_ready[p] = zero_hit | ~busy[idx] | wb_hit[idx];
    end

    // A same-cycle retirement of the destination frees it for a new issue.
    assign issue_ok   = i_issue_en & ~stall & ~clr & (~busy[i_issue_reg] | wb_hit[i_issue_reg]);
    assign issue_sets = issue_ok & ~(HAS_ZERO & (i_issue_reg == '0));
    assign o_issue_ok = issue_ok;
    assign o_busy_cnt = busy_cnt;

    always_comb begin
        set_mask = '0;
        if (issue_sets) begin
            set_mask[i_issue_reg] = 1'b1;
        end
        cleared = busy & wb_hit & ~set_mask;
        inc     = issue_sets & ~busy[i_issue_reg];
        dec_cnt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            dec_cnt = dec_cnt + (REG_IDX_W+1)'(cleared[r]);
        end
        if (clr) begin
            busy_next     = '0;
            busy_cnt_next = '0;
        end else begin
            busy_next     = (busy & ~wb_hit) | set_mask;
            busy_cnt_next = busy_cnt - dec_cnt + (REG_IDX_W+1)'(inc);
        end
    end

    always_ff @(posedge clk or negedge rf_reset) begin
        if (!rf_reset) begin
            busy     <= '0;
            busy_cnt <= '0;
            // NOTE: the array is reset on purpose, reads must return 0 right after reset;
            // this forces flops rather than a RAM macro.
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            busy     <= busy_next;
            busy_cnt <= busy_cnt_next;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wb_hit[r]) begin
                    regs[r] <= wb_val[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_rf_scoreboard;

    localparam int WW = 32;
    localparam int IW = 5;

    typedef enum int {K_D0, K_D1, K_RDY0, K_RDY1, K_ISSUE, K_CNT} kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic            clk = 1'b0;
    logic            rf_reset;
    logic            clr;
    logic            stall;
    logic [2*IW-1:0] i_rd_idx;
    logic [2*WW-1:0] o_rd_data;
    logic [1:0]      o_rd_ready;
    logic            i_issue_en;
    logic [IW-1:0]   i_issue_reg;
    logic            o_issue_ok;
    logic [1:0]      i_wb_en;
    logic [2*IW-1:0] i_wb_reg;
    logic [2*WW-1:0] i_wb_data;
    logic [IW:0]     o_busy_cnt;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    rf_scoreboard #(
        .WORD_W(WW), .REG_IDX_W(IW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rf_reset(rf_reset), .clr(clr), .stall(stall),
        .i_rd_idx(i_rd_idx), .o_rd_data(o_rd_data), .o_rd_ready(o_rd_ready),
        .i_issue_en(i_issue_en), .i_issue_reg(i_issue_reg), .o_issue_ok(o_issue_ok),
        .i_wb_en(i_wb_en), .i_wb_reg(i_wb_reg), .i_wb_data(i_wb_data),
        .o_busy_cnt(o_busy_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t  e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.kind)
                K_D0:    act = o_rd_data[31:0];
                K_D1:    act = o_rd_data[63:32];
                K_RDY0:  act = {31'd0, o_rd_ready[0]};
                K_RDY1:  act = {31'd0, o_rd_ready[1]};
                K_ISSUE: act = {31'd0, o_issue_ok};
                default: act = {26'd0, o_busy_cnt};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s (cycle %0d): actual=0x%08h required=0x%08h", e.name, e.cyc, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        i_issue_en = 1'b0;
        i_wb_en    = '0;
        clr        = 1'b0;
        stall      = 1'b0;
    endtask

    task automatic expect_out(input kind_t k, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.exp  = v;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic wb(input int port, input int r, input logic [31:0] d);
        i_wb_en[port]               = 1'b1;
        i_wb_reg[port*IW +: IW]     = IW'(r);
        i_wb_data[port*WW +: WW]    = d;
    endtask

    task automatic issue(input int r);
        i_issue_en  = 1'b1;
        i_issue_reg = IW'(r);
    endtask

    task automatic rd(input int port, input int r);
        i_rd_idx[port*IW +: IW] = IW'(r);
    endtask

    initial begin
        rf_reset = 1'b0; clr = 1'b0; stall = 1'b0; i_rd_idx = '0;
        i_issue_en = 1'b0; i_issue_reg = '0; i_wb_en = '0; i_wb_reg = '0; i_wb_data = '0;
        repeat (2) @(posedge clk);

        // Reset state, then release
        step(); rd(0, 5); rd(1, 3);
        expect_out(K_D0, 32'h0, "reset_rd_data"); expect_out(K_RDY0, 1, "reset_rd_ready");
        expect_out(K_CNT, 0, "reset_busy_cnt");
        rf_reset = 1'b1;

        step(); wb(0, 5, 32'hDEADBEEF);
        expect_out(K_D0, 32'hDEADBEEF, "wb5_bypass");
        step();
        expect_out(K_D0, 32'hDEADBEEF, "wb5_stored"); expect_out(K_RDY0, 1, "wb5_ready");
        expect_out(K_CNT, 0, "wb5_cnt");

        // Issue / WAW block / retire with bypass
        step(); issue(3); rd(1, 3);
        expect_out(K_ISSUE, 1, "issue3_ok"); expect_out(K_RDY1, 1, "issue3_ready_pre");
        step(); issue(3);
        expect_out(K_ISSUE, 0, "issue3_waw_block"); expect_out(K_RDY1, 0, "reg3_pending");
        expect_out(K_CNT, 1, "issue3_cnt");
        step(); wb(0, 3, 32'h12);
        expect_out(K_D1, 32'h12, "wb3_bypass"); expect_out(K_RDY1, 1, "wb3_bypass_ready");
        expect_out(K_CNT, 1, "wb3_cnt_before");
        step();
        expect_out(K_D1, 32'h12, "wb3_stored"); expect_out(K_CNT, 0, "wb3_cnt_after");

        // Issue and WB on same register: issue wins busy
        step(); issue(7); wb(0, 7, 32'h55); rd(0, 7);
        expect_out(K_ISSUE, 1, "iss_wb7_ok"); expect_out(K_D0, 32'h55, "iss_wb7_bypass");
        step();
        expect_out(K_D0, 32'h55, "iss_wb7_stored"); expect_out(K_RDY0, 0, "iss_wb7_busy");
        expect_out(K_CNT, 1, "iss_wb7_cnt");

        // Register 0 hardwired
        step(); wb(0, 0, 32'hFFFFFFFF); issue(0); rd(1, 0);
        expect_out(K_ISSUE, 1, "issue0_ok"); expect_out(K_D1, 0, "zero_bypass");
        expect_out(K_RDY1, 1, "zero_ready_bypass");
        step();
        expect_out(K_D1, 0, "zero_stored"); expect_out(K_RDY1, 1, "zero_ready");
        expect_out(K_CNT, 1, "zero_cnt_unchanged");

        // Fill 1,2,4 (retiring 7 on port 1), then flush with a WB to 2
        step(); issue(1); wb(1, 7, 32'h77);
        expect_out(K_ISSUE, 1, "issue1_ok");
        step(); issue(2);
        expect_out(K_ISSUE, 1, "issue2_ok"); expect_out(K_CNT, 1, "cnt_after_1");
        step(); issue(4);
        expect_out(K_ISSUE, 1, "issue4_ok"); expect_out(K_CNT, 2, "cnt_after_2");
        step(); clr = 1'b1; wb(0, 2, 32'h9); issue(10); rd(0, 2); rd(1, 1);
        expect_out(K_CNT, 3, "cnt_three_busy"); expect_out(K_ISSUE, 0, "clr_issue_reject");
        expect_out(K_D0, 32'h9, "clr_wb2_bypass"); expect_out(K_RDY1, 0, "reg1_busy_pre_clr");
        step(); rd(1, 4);
        expect_out(K_CNT, 0, "clr_cnt_zero"); expect_out(K_D0, 32'h9, "clr_wb2_stored");
        expect_out(K_RDY0, 1, "clr_ready2"); expect_out(K_RDY1, 1, "clr_ready4");

        // Two ports to one register, stall blocks issue
        step(); wb(0, 8, 32'hA); wb(1, 8, 32'hB); stall = 1'b1; issue(9); rd(0, 8); rd(1, 9);
        expect_out(K_D0, 32'hB, "dual_wb_bypass"); expect_out(K_ISSUE, 0, "stall_reject");
        step(); issue(9);
        expect_out(K_D0, 32'hB, "dual_wb_stored"); expect_out(K_RDY1, 1, "reg9_not_busy");
        expect_out(K_ISSUE, 1, "issue9_ok"); expect_out(K_CNT, 0, "stall_cnt");
        step();
        expect_out(K_CNT, 1, "issue9_cnt"); expect_out(K_RDY1, 0, "reg9_busy");

        // Reset mid-sequence
        step(); rf_reset = 1'b0; rd(0, 5); rd(1, 8);
        expect_out(K_D0, 0, "midrst_rd5"); expect_out(K_D1, 0, "midrst_rd8");
        expect_out(K_CNT, 0, "midrst_cnt");
        step(); rf_reset = 1'b1; rd(0, 7); rd(1, 9);
        expect_out(K_D0, 0, "post_rst_rd7"); expect_out(K_RDY1, 1, "post_rst_ready9");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
